// File: rtl/control_fsm.sv
//==============================================================================
// Module   : control_fsm
// Purpose  : Multicycle control unit for the 8-bit accumulator CPU. Decodes
//            the instruction at the current Pc and sequences the datapath
//            enables/selects, the handshaked IN instruction, HALT, and a
//            retired-instruction counter.
// Options  : CONTROL_SINGLE_STEP_EN - FETCH waits for Step before advancing.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package opcodes;
    typedef enum logic [2:0] {
        ALU_PASSA = 3'd0,
        ALU_PASSB = 3'd1,
        ALU_ADD   = 3'd2,
        ALU_SUB   = 3'd3,
        ALU_AND   = 3'd4,
        ALU_OR    = 3'd5
    } alu_functions_t;

    typedef enum logic {
        PcInc = 1'b0,
        PcJmp = 1'b1
    } PcSel_t;
endpackage

module control_fsm #(
    parameter int n     = 8,
    parameter int cnt_n = 8
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [n-1:0]           MemData,
    input  logic [n-1:0]           Acc,
    input  logic                   Button,
    input  logic                   Step,
    output logic                   RegWe,
    output logic                   ImmSel,
    output logic                   WDataSel,
    output logic                   AccStore,
    output logic                   Op1Sel,
    output logic                   PcWe,
    output opcodes::alu_functions_t AluOp,
    output opcodes::PcSel_t        PcSel,
    output logic                   InWait,
    output logic                   Halted,
    output logic [cnt_n-1:0]       InstrCount
);
    import opcodes::*;

    localparam logic [3:0] c_OP_NOP  = 4'h0;
    localparam logic [3:0] c_OP_LDI  = 4'h1;
    localparam logic [3:0] c_OP_LDIH = 4'h2;
    localparam logic [3:0] c_OP_LD   = 4'h3;
    localparam logic [3:0] c_OP_ST   = 4'h4;
    localparam logic [3:0] c_OP_ADD  = 4'h5;
    localparam logic [3:0] c_OP_SUB  = 4'h6;
    localparam logic [3:0] c_OP_AND  = 4'h7;
    localparam logic [3:0] c_OP_OR   = 4'h8;
    localparam logic [3:0] c_OP_ADDI = 4'h9;
    localparam logic [3:0] c_OP_IN   = 4'hA;
    localparam logic [3:0] c_OP_JMP  = 4'hB;
    localparam logic [3:0] c_OP_JZ   = 4'hC;
    localparam logic [3:0] c_OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_EXEC    = 2'd1,
        S_WAIT_IN = 2'd2,
        S_HALT    = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [cnt_n-1:0] r_count;
    logic             w_count_inc;
    logic             r_button;
    logic             w_button_rise;
    logic [3:0]       w_opcode;
    logic             w_acc_zero;

`ifndef CONTROL_SINGLE_STEP_EN
    // Step has no effect when single-stepping is compiled out.
    logic w_step_unused;
    assign w_step_unused = Step;
`endif

    // A rising edge needs Button to have been low on the previous cycle, so a
    // level held high across a completed IN cannot fire the next IN.
    assign w_button_rise = Button & ~r_button;
    assign w_opcode      = MemData[7:4];
    assign w_acc_zero    = (Acc == '0);

    assign InWait     = (r_state == S_WAIT_IN);
    assign Halted     = (r_state == S_HALT);
    assign InstrCount = r_count;

    // State register, retired-instruction counter and Button history.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state  <= S_FETCH;
            r_count  <= '0;
            r_button <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_button <= Button;
            if (w_count_inc) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Next-state and datapath control decode; everything is held at its idle
    // value while Reset is high so nothing commits on a reset cycle.
    always_comb begin
        w_next      = r_state;
        w_count_inc = 1'b0;
        RegWe       = 1'b0;
        ImmSel      = 1'b0;
        WDataSel    = 1'b0;
        AccStore    = 1'b0;
        Op1Sel      = 1'b0;
        PcWe        = 1'b0;
        AluOp       = ALU_PASSB;
        PcSel       = PcInc;

        if (!Reset) begin
            case (r_state)
                S_FETCH: begin
`ifdef CONTROL_SINGLE_STEP_EN
                    if (Step) begin
                        w_next = S_EXEC;
                    end
`else
                    w_next = S_EXEC;
`endif
                end

                S_EXEC: begin
                    w_next      = S_FETCH;
                    w_count_inc = 1'b1;
                    PcWe        = 1'b1;
                    case (w_opcode)
                        c_OP_NOP: ;
                        c_OP_LDI: begin
                            Op1Sel   = 1'b1;
                            AluOp    = ALU_PASSA;
                            AccStore = 1'b1;
                        end
                        c_OP_LDIH: begin
                            Op1Sel   = 1'b1;
                            ImmSel   = 1'b1;
                            AluOp    = ALU_PASSA;
                            AccStore = 1'b1;
                        end
                        c_OP_LD: begin
                            AluOp    = ALU_PASSA;
                            AccStore = 1'b1;
                        end
                        c_OP_ST: begin
                            RegWe = 1'b1;
                        end
                        c_OP_ADD: begin
                            AluOp    = ALU_ADD;
                            AccStore = 1'b1;
                        end
                        c_OP_SUB: begin
                            AluOp    = ALU_SUB;
                            AccStore = 1'b1;
                        end
                        c_OP_AND: begin
                            AluOp    = ALU_AND;
                            AccStore = 1'b1;
                        end
                        c_OP_OR: begin
                            AluOp    = ALU_OR;
                            AccStore = 1'b1;
                        end
                        c_OP_ADDI: begin
                            Op1Sel   = 1'b1;
                            AluOp    = ALU_ADD;
                            AccStore = 1'b1;
                        end
                        c_OP_IN: begin
                            // Retirement and the PC step happen when Button arrives.
                            PcWe        = 1'b0;
                            w_count_inc = 1'b0;
                            w_next      = S_WAIT_IN;
                        end
                        c_OP_JMP: begin
                            PcSel = PcJmp;
                        end
                        c_OP_JZ: begin
                            if (w_acc_zero) begin
                                AluOp = ALU_PASSA;
                                PcSel = PcJmp;
                            end
                        end
                        c_OP_HALT: begin
                            PcWe   = 1'b0;
                            w_next = S_HALT;
                        end
                        default: ;  // reserved opcodes behave as NOP
                    endcase
                end

                S_WAIT_IN: begin
                    if (w_button_rise) begin
                        RegWe       = 1'b1;
                        WDataSel    = 1'b1;
                        PcWe        = 1'b1;
                        w_count_inc = 1'b1;
                        w_next      = S_FETCH;
                    end
                end

                S_HALT: ;

                default: w_next = S_FETCH;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_control_fsm.sv
//==============================================================================
// Module   : tb_control_fsm
// Purpose  : Directed self-checking bench for control_fsm, driving it from a
//            small accumulator datapath model (ROM, register file, Acc, Pc).
// Options  : CONTROL_SINGLE_STEP_EN - enables the single-step scenario.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_control_fsm;
    import opcodes::*;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [7:0]  MemData;
    logic [7:0]  Acc;
    logic        Button;
    logic        Step;
    logic        RegWe, ImmSel, WDataSel, AccStore, Op1Sel, PcWe;
    alu_functions_t AluOp;
    PcSel_t      PcSel;
    logic        InWait, Halted;
    logic [7:0]  InstrCount;

    int total = 0;
    int bad   = 0;

    control_fsm #(.n(8), .cnt_n(8)) dut (
        .Clock(Clock), .Reset(Reset), .MemData(MemData), .Acc(Acc),
        .Button(Button), .Step(Step),
        .RegWe(RegWe), .ImmSel(ImmSel), .WDataSel(WDataSel),
        .AccStore(AccStore), .Op1Sel(Op1Sel), .PcWe(PcWe),
        .AluOp(AluOp), .PcSel(PcSel),
        .InWait(InWait), .Halted(Halted), .InstrCount(InstrCount)
    );

    always #5 Clock = ~Clock;

    // Datapath model
    localparam logic [7:0] c_SWITCHES = 8'hA5;
    logic [7:0] rom [16];
    logic [7:0] init_regs [16];
    logic [7:0] init_acc;
    logic       init_load;
    logic [7:0] m_pc, m_acc;
    logic [7:0] m_regs [16];
    logic [7:0] w_op1, w_alu;

    assign MemData = rom[m_pc[3:0]];
    assign Acc     = m_acc;

    // ALU operand selection and function of the model datapath.
    always_comb begin
        if (Op1Sel) w_op1 = ImmSel ? {MemData[3:0], 4'h0} : {4'h0, MemData[3:0]};
        else        w_op1 = m_regs[MemData[3:0]];
        case (AluOp)
            ALU_PASSA: w_alu = w_op1;
            ALU_PASSB: w_alu = m_acc;
            ALU_ADD:   w_alu = m_acc + w_op1;
            ALU_SUB:   w_alu = m_acc - w_op1;
            ALU_AND:   w_alu = m_acc & w_op1;
            ALU_OR:    w_alu = m_acc | w_op1;
            default:   w_alu = m_acc;
        endcase
    end

    // Datapath commit on each rising edge; Reset clears Pc and optionally preloads state.
    always @(posedge Clock) begin
        if (AccStore) m_acc <= w_alu;
        if (RegWe)    m_regs[MemData[3:0]] <= WDataSel ? c_SWITCHES : m_acc;
        if (PcWe)     m_pc <= (PcSel == PcJmp) ? w_alu : m_pc + 8'd1;
        if (Reset) begin
            m_pc <= 8'd0;
            if (init_load) begin
                m_acc <= init_acc;
                for (int i = 0; i < 16; i++) m_regs[i] <= init_regs[i];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    task automatic clear_init();
        init_acc  = 8'h00;
        init_load = 1'b1;
        for (int i = 0; i < 16; i++) init_regs[i] = 8'h00;
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    endtask

    initial begin
        Reset  = 1'b1;
        Button = 1'b0;
        Step   = 1'b1;
        clear_init();

        // Reset state, observed while Reset is still asserted
        rom[0] = 8'h15; rom[1] = 8'h43; rom[2] = 8'h33; rom[3] = 8'hF0;
        tick();
        chk("rst_count",    InstrCount, 0);
        chk("rst_inwait",   InWait, 0);
        chk("rst_halted",   Halted, 0);
        chk("rst_enables",  {RegWe, ImmSel, WDataSel, AccStore, Op1Sel, PcWe}, 0);
        chk("rst_aluop",    AluOp, ALU_PASSB);
        chk("rst_pcsel",    PcSel, PcInc);
        Reset = 1'b0;

        // LDI 5; ST R3; LD R3; HALT
        chk("p1_fetch_pcwe", PcWe, 0);
        ticks(8);
        chk("p1_halted", Halted, 1);
        chk("p1_count",  InstrCount, 4);
        chk("p1_acc",    m_acc, 8'h05);
        chk("p1_r3",     m_regs[3], 8'h05);
        chk("p1_pc",     m_pc, 8'h03);
        chk("p1_halt_pcwe", PcWe, 0);
        ticks(3);
        chk("p1_halt_stays", Halted, 1);

        // LDI 7; ADD R3; SUB R3
        clear_init();
        init_regs[3] = 8'h05;
        rom[0] = 8'h17; rom[1] = 8'h53; rom[2] = 8'h63; rom[3] = 8'hF0;
        do_reset();
        tick();
        chk("p2_op_ldi",  AluOp, ALU_PASSA);
        chk("p2_st_ldi",  AccStore, 1);
        chk("p2_sel_ldi", {Op1Sel, ImmSel}, 2'b10);
        tick();
        chk("p2_st_off1", AccStore, 0);
        chk("p2_acc7",    m_acc, 8'h07);
        tick();
        chk("p2_op_add",  AluOp, ALU_ADD);
        chk("p2_st_add",  AccStore, 1);
        tick();
        chk("p2_st_off2", AccStore, 0);
        chk("p2_acc12",   m_acc, 8'h0C);
        tick();
        chk("p2_op_sub",  AluOp, ALU_SUB);
        tick();
        chk("p2_acc7b",   m_acc, 8'h07);

        // LDIH A; OR R3; AND R3; ADDI 3; reserved D; HALT
        clear_init();
        init_regs[3] = 8'h05;
        rom[0] = 8'h2A; rom[1] = 8'h83; rom[2] = 8'h73; rom[3] = 8'h93;
        rom[4] = 8'hD0; rom[5] = 8'hF0;
        do_reset();
        tick();
        chk("p3_ldih_sel", {Op1Sel, ImmSel}, 2'b11);
        tick();
        chk("p3_accA0", m_acc, 8'hA0);
        ticks(2);
        chk("p3_accA5", m_acc, 8'hA5);
        ticks(2);
        chk("p3_acc05", m_acc, 8'h05);
        ticks(2);
        chk("p3_acc08", m_acc, 8'h08);
        ticks(4);
        chk("p3_count", InstrCount, 6);
        chk("p3_pc",    m_pc, 8'h05);
        chk("p3_halt",  Halted, 1);

        // JZ r2 with Acc == 0 jumps to R2
        clear_init();
        init_regs[2] = 8'h10;
        rom[0] = 8'hC2;
        do_reset();
        tick();
        chk("p4_jz_pcsel", PcSel, PcJmp);
        chk("p4_jz_pcwe",  PcWe, 1);
        tick();
        chk("p4_jz_pc",    m_pc, 8'h10);

        // JZ r2 with Acc != 0 falls through
        init_acc = 8'h01;
        do_reset();
        tick();
        chk("p4_jnz_pcsel", PcSel, PcInc);
        tick();
        chk("p4_jnz_pc",    m_pc, 8'h01);

        // JMP takes Pc from Acc
        clear_init();
        init_acc = 8'h07;
        rom[0] = 8'hB0;
        do_reset();
        ticks(2);
        chk("p4_jmp_pc", m_pc, 8'h07);

        // IN r1 with Button held high from before reset; then IN r2 must not retrigger
        clear_init();
        rom[0] = 8'hA1; rom[1] = 8'hA2; rom[2] = 8'hF0;
        Button = 1'b1;
        do_reset();
        tick();
        chk("p5_in_exec_pcwe", PcWe, 0);
        tick();
        chk("p5_inwait", InWait, 1);
        ticks(3);
        chk("p5_inwait_held", InWait, 1);
        chk("p5_no_regwe",    RegWe, 0);
        Button = 1'b0;
        tick();
        chk("p5_inwait_low", InWait, 1);
        Button = 1'b1;
        #1;
        chk("p5_fire", {RegWe, WDataSel, PcWe}, 3'b111);
        tick();
        chk("p5_done_inwait", InWait, 0);
        chk("p5_r1",          m_regs[1], c_SWITCHES);
        chk("p5_count",       InstrCount, 1);
        chk("p5_pc",          m_pc, 8'h01);
        ticks(6);
        chk("p5_noretrig_wait",  InWait, 1);
        chk("p5_noretrig_count", InstrCount, 1);

        // Reset wins over a Button edge in WAIT_IN
        init_load = 1'b0;
        Button = 1'b0;
        tick();
        Button = 1'b1;
        Reset  = 1'b1;
        #1;
        chk("p6_rst_regwe", {RegWe, PcWe}, 2'b00);
        tick();
        Reset = 1'b0;
        chk("p6_inwait", InWait, 0);
        chk("p6_count",  InstrCount, 0);
        chk("p6_r2",     m_regs[2], 8'h00);
        chk("p6_pc",     m_pc, 8'h00);
        Button = 1'b0;

        // InstrCount wraps 255 -> 0
        clear_init();
        do_reset();
        ticks(510);
        chk("p7_count_ff", InstrCount, 8'hFF);
        ticks(2);
        chk("p7_count_wrap", InstrCount, 8'h00);

`ifdef CONTROL_SINGLE_STEP_EN
        // FETCH holds without Step; one Step pulse retires exactly one instruction
        clear_init();
        Step = 1'b0;
        do_reset();
        ticks(10);
        chk("p8_hold_pc",    m_pc, 8'h00);
        chk("p8_hold_count", InstrCount, 0);
        Step = 1'b1;
        tick();
        Step = 1'b0;
        tick();
        chk("p8_step_count", InstrCount, 1);
        chk("p8_step_pc",    m_pc, 8'h01);
        ticks(6);
        chk("p8_step_once",  InstrCount, 1);
`else
        // Step low does not stall FETCH
        clear_init();
        Step = 1'b0;
        do_reset();
        ticks(2);
        chk("p8_nostep_count", InstrCount, 1);
        chk("p8_nostep_pc",    m_pc, 8'h01);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
